// File: rtl/ms_par_acc_capture.sv
// ms_par_acc_capture: framed popcount accumulator with saturating count and valid/ready result
module ms_par_acc_capture #(
  parameter int LANES = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             en,
  input  logic [LANES-1:0] data_in,
  input  logic             done_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow,
  output logic             busy
);
  localparam int PCW = $clog2(LANES + 1);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] acc, sat;
  logic [PCW-1:0] pc;
  logic [WIDTH:0] sum;
  always_comb begin
    pc = '0;
    for (int i = 0; i < LANES; i++) pc = pc + PCW'(data_in[i]);
    sum = {1'b0, acc} + (en ? (WIDTH+1)'(pc) : '0);
    sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE: state_d = start ? ACC : IDLE;
      ACC:  state_d = done_in ? HOLD : ACC;
      HOLD: state_d = result_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc <= '0;
      result <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && start) begin
        acc <= '0;
        overflow <= 1'b0;
      end else if (state == ACC) begin
        acc <= sat;
        if (sum[WIDTH]) overflow <= 1'b1;
        if (done_in) result <= sat;
      end
    end
  end
  assign result_valid = (state == HOLD);
  assign busy = (state == ACC);
endmodule

// File: tb/tb_ms_par_acc_capture.sv
// tb_ms_par_acc_capture: randomized scoreboard bench for the capture stage
module tb_ms_par_acc_capture;
  localparam int LANES = 4;
  localparam int WIDTH = 10;
  localparam int MAXV = (1 << WIDTH) - 1;
  logic clk = 0, rst = 0, start = 0, en = 0, done_in = 0, result_ready = 0;
  logic [LANES-1:0] data_in = '0;
  logic [WIDTH-1:0] result;
  logic result_valid, overflow, busy;
  int total = 0, bad = 0;
  logic [WIDTH:0] sb[$];
  logic [LANES-1:0] pat_q[$];
  bit en_q[$];
  bit seen = 0;
  logic [WIDTH-1:0] cap_res;
  logic cap_ov;

  ms_par_acc_capture #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .en(en), .data_in(data_in),
    .done_in(done_in), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: result must hold steady through HOLD and match the model on handshake
  always @(negedge clk) begin
    if (!rst) seen = 0;
    else if (result_valid) begin
      if (!seen) begin
        cap_res = result;
        cap_ov = overflow;
        seen = 1;
      end else begin
        chk("hold_result_stable", int'(result), int'(cap_res));
        chk("hold_ovf_stable", int'(overflow), int'(cap_ov));
      end
      if (result_ready) begin
        if (sb.size() == 0) chk("sb_unexpected_result", 1, 0);
        else begin
          logic [WIDTH:0] e;
          e = sb.pop_front();
          chk("result", int'(result), int'(e[WIDTH-1:0]));
          chk("overflow", int'(overflow), int'(e[WIDTH]));
        end
        seen = 0;
      end
    end
  end

  task automatic add(logic [LANES-1:0] p, bit e);
    pat_q.push_back(p);
    en_q.push_back(e);
  endtask

  task automatic run(int rdly);
    int n, tot;
    bit exp_o;
    int exp_r;
    n = pat_q.size();
    tot = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_on_start", busy, 1);
    chk("ovf_cleared", overflow, 0);
    for (int i = 0; i < n; i++) begin
      data_in = pat_q[i];
      en = en_q[i];
      done_in = (i == n - 1);
      start = 1'($urandom_range(0, 1));
      if (en_q[i]) tot += $countones(pat_q[i]);
      @(posedge clk); #1;
      if (i < n - 1) begin
        chk("busy_acc", busy, 1);
        chk("no_early_valid", result_valid, 0);
      end
    end
    done_in = 0; start = 0; en = 0;
    exp_o = tot > MAXV;
    exp_r = exp_o ? MAXV : tot;
    sb.push_back({exp_o, WIDTH'(exp_r)});
    chk("valid_latency", result_valid, 1);
    chk("busy_off", busy, 0);
    repeat (rdly) begin
      start = 1'($urandom_range(0, 1));
      done_in = 1'($urandom_range(0, 1));
      data_in = LANES'($urandom);
      en = 1;
      @(posedge clk); #1;
      chk("valid_held", result_valid, 1);
    end
    result_ready = 1; start = 1; done_in = 0;
    @(posedge clk); #1;
    result_ready = 0; start = 0; en = 0;
    chk("valid_drop", result_valid, 0);
    chk("start_in_handshake_ignored", busy, 0);
    chk("ovf_after_handshake", overflow, int'(exp_o));
    @(posedge clk); #1;
    pat_q.delete();
    en_q.delete();
  endtask

  initial begin
    #1;
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    #12 rst = 1;
    @(posedge clk); #1;
    // full count
    repeat (8) add(4'b1111, 1);
    run(0);
    // gating and popcount
    add(4'b1010, 1); add(4'b0111, 0); add(4'b0001, 1); add(4'b1111, 1);
    run(1);
    // minimum run
    add(4'b0110, 1);
    run(0);
    // saturation, then next run must clear overflow
    repeat (300) add(4'b1111, 1);
    run(2);
    add(4'b0001, 1);
    run(0);
    // backpressure
    repeat (5) add(4'b1011, 1);
    run(20);
    // abort on the 3rd ACC cycle
    start = 1;
    @(posedge clk); #1;
    start = 0; data_in = 4'b1111; en = 1; done_in = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_ovf", overflow, 0);
    chk("abort_busy", busy, 0);
    #2 rst = 1; en = 0;
    @(posedge clk); #1;
    chk("post_abort_valid", result_valid, 0);
    chk("post_abort_busy", busy, 0);
    add(4'b0011, 1); add(4'b0011, 1);
    run(0);
    // random runs
    for (int r = 0; r < 25; r++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) add(LANES'($urandom), 1'($urandom_range(0, 1)));
      run($urandom_range(0, 5));
    end
    repeat (2) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ms_par_acc_capture.md
# ms_par_acc_capture

Downstream stage of the multi-input serial stochastic multiplier. Each cycle it consumes the `LANES` parallel product bitstream lanes, popcounts them, and accumulates into a `WIDTH`-bit saturating count. It ends the run on the multiplier's `done` strobe and presents the final binary result through a valid/ready handshake. It replaces the free-running per-lane-count accumulators with a framed, start/stop-controlled capture stage.

## Interface
- `LANES`, default 4: product bitstream lanes per cycle (2**NUM_INPUTS upstream); legal 2..32.
- `WIDTH`, default 10: accumulator/result width (DATA_WIDTH*NUM_INPUTS upstream).
- `PCW`, derived as $clog2(LANES+1): popcount width; not overridden.

- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new run; honoured only in IDLE.
- `en`  in  1  lane-data qualifier; data is accumulated only when en=1 in ACC.
- `data_in`  in  LANES  product bitstream bits for this cycle.
- `done_in`  in  1  end-of-run strobe from the multiplier (last SNG overflow).
- `result`  out  WIDTH  captured final count; stable while result_valid=1.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts result.
- `overflow`  out  1  sticky; count saturated during the current/last run.
- `busy`  out  1  high in ACC.

## Operation
- FSM states: IDLE, ACC, HOLD. Reset state is IDLE.
- IDLE:
  - `start`=1 clears `acc` and `overflow`, then goes to ACC.
  - `done_in`, `en` and `data_in` are ignored.
  - `result` keeps its last captured value.
- ACC, each cycle:
  - `inc` = en ? popcount(data_in) : 0.
  - `sum` = acc + inc, computed at WIDTH+1 bits.
  - If sum > 2**WIDTH-1: acc <= 2**WIDTH-1 and overflow <= 1 (sticky). Otherwise acc <= sum.
- ACC with `done_in`=1:
  - That cycle's `inc` is included.
  - `result` <= the saturated sum, and the FSM goes to HOLD.
  - `start` in ACC is ignored.
- HOLD:
  - `result_valid`=1.
  - When `result_ready`=1, the FSM goes to IDLE and `result_valid` drops next cycle.
  - `start`, `done_in` and data are ignored, including a `start` in the handshake cycle.
- Arithmetic is unsigned; popcount is an unsigned sum of LANES bits, zero-extended to WIDTH+1.

## Timing
- Reset (`rst`=0, async):
  - State=IDLE.
  - acc=0, result=0, result_valid=0, overflow=0, busy=0.
  - Takes effect immediately, without waiting for a clock edge.
- Reset mid-ACC or mid-HOLD discards the run. No partial result is presented.
- Start cycle: the start edge clears acc. Data in the start cycle is NOT accumulated; the first accumulated sample is the cycle after `start`. `busy`=1 from that cycle.
- Latency: `result_valid` rises on the edge after the cycle in which `done_in`=1 is sampled in ACC, so 1 cycle. `busy` falls on the same edge.
- Minimum run: start, then a single ACC cycle with done_in=1, then valid. The result equals that one cycle's inc.
- Throughput:
  - With `result_ready` tied high, HOLD lasts 1 cycle and IDLE at least 1 cycle.
  - Back-to-back runs therefore need `start` no earlier than 2 cycles after valid rises.
- Backpressure: `result` and `overflow` must not change while result_valid=1 and result_ready=0, for any number of cycles.
- `overflow` remains readable after the handshake until the next accepted `start`.

## Test plan
- Reset: apply rst=0 mid-stream → all outputs 0 asynchronously. Release → IDLE, result_valid=0.
- Full count: LANES=4, WIDTH=10. Start, then 8 cycles data_in=4'b1111 en=1 with done_in on the 8th → result=32, overflow=0, valid 1 cycle after done.
- Gating and popcount: data_in pattern 4'b1010, 4'b0111, 4'b0001, 4'b1111, with en=0 on the 2nd cycle, done on the 4th → result=2+0+1+4=7.
- Saturation: WIDTH=5, LANES=4. 10 cycles all-ones → result=31, overflow=1. Next start → overflow clears to 0.
- Backpressure: hold result_ready=0 for 20 cycles after valid → result and valid stable. Pulse start and done_in during HOLD → ignored. Assert ready → valid drops next cycle, then IDLE.
- Abort: rst=0 at the 3rd ACC cycle of a run → no valid. A fresh run of 2 cycles of 4'b0011 → result=4, with no residue from the aborted run.
